agc_io_channel_bank: RTL and testbench

//  Parametrised IO channel bank between Core (IO_read_sel/IO_write_sel ports) and external serial/AXI adapters.

---
 rtl/agc_io_channel_bank_if.sv | 34 +++
 rtl/agc_io_channel_bank.sv | 143 ++++++++++++++
 tb/tb_agc_io_channel_bank.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/agc_io_channel_bank_if.sv
// Bus bundle between the AGC IO channel bank, the Core IO select ports and the
// external input/output adapters. The bank takes the slave side.
interface agc_io_channel_bank_if #(
  parameter int unsigned NUM_IN  = 5,
  parameter int unsigned NUM_OUT = 4,
  parameter int unsigned WIDTH   = 15,
  parameter int unsigned SEL_W   = 5
);
  logic [NUM_IN*WIDTH-1:0]  in_data;
  logic [NUM_IN-1:0]        in_valid;
  logic [NUM_IN-1:0]        in_ready;
  logic [NUM_OUT*WIDTH-1:0] out_data;
  logic [NUM_OUT-1:0]       out_valid;
  logic [NUM_OUT-1:0]       out_ready;
  logic [SEL_W-1:0]         IO_read_sel;
  logic [WIDTH-1:0]         IO_read_data;
  logic [SEL_W-1:0]         IO_write_sel;
  logic [WIDTH-1:0]         IO_write_data;
  logic                     IO_write_en;
  logic                     stall;
  logic                     irq;

  modport slave (
    input  in_data, in_valid, out_ready, IO_read_sel, IO_write_sel, IO_write_data, IO_write_en,
           stall,
    output in_ready, out_data, out_valid, IO_read_data, irq
  );

  modport master (
    output in_data, in_valid, out_ready, IO_read_sel, IO_write_sel, IO_write_data, IO_write_en,
           stall,
    input  in_ready, out_data, out_valid, IO_read_data, irq
  );
endinterface

// File: rtl/agc_io_channel_bank.sv
// Parametrised AGC IO channel bank: NUM_IN captured input words with fresh/overrun status,
// NUM_OUT handshaked output registers, a registered stall-aware Core read port and a masked irq.
module agc_io_channel_bank #(
  parameter int unsigned NUM_IN  = 5,
  parameter int unsigned NUM_OUT = 4,
  parameter int unsigned WIDTH   = 15,
  parameter int unsigned SEL_W   = 5
) (
  input logic                  clock,
  input logic                  reset_n,
  agc_io_channel_bank_if.slave bus
);

  if (NUM_IN + 3 > 2 ** SEL_W) begin : g_err_read_map
    $error("agc_io_channel_bank: read map does not fit in SEL_W");
  end
  if (NUM_OUT + 2 > 2 ** SEL_W) begin : g_err_write_map
    $error("agc_io_channel_bank: write map does not fit in SEL_W");
  end
  if (NUM_IN + NUM_OUT > WIDTH) begin : g_err_status_width
    $error("agc_io_channel_bank: overrun status does not fit in WIDTH");
  end

  localparam logic [SEL_W-1:0] SelFresh = SEL_W'(NUM_IN);
  localparam logic [SEL_W-1:0] SelOvr   = SEL_W'(NUM_IN + 1);
  localparam logic [SEL_W-1:0] SelMaskR = SEL_W'(NUM_IN + 2);
  localparam logic [SEL_W-1:0] SelMaskW = SEL_W'(NUM_OUT);
  localparam logic [SEL_W-1:0] SelW1c   = SEL_W'(NUM_OUT + 1);

  logic [NUM_IN-1:0][WIDTH-1:0]  in_reg_q, in_reg_d;
  logic [NUM_IN-1:0]             fresh_q, fresh_d;
  logic [NUM_IN-1:0]             in_ovr_q, in_ovr_d;
  logic [NUM_IN-1:0]             irq_mask_q, irq_mask_d;
  logic [NUM_OUT-1:0][WIDTH-1:0] out_reg_q, out_reg_d;
  logic [NUM_OUT-1:0]            out_valid_q, out_valid_d;
  logic [NUM_OUT-1:0]            out_ovr_q, out_ovr_d;
  logic [WIDTH-1:0]              rd_data_q, rd_data_d;

  logic [NUM_IN-1:0]  in_ready;
  logic [NUM_IN-1:0]  cap;
  logic [NUM_IN-1:0]  rd_clr;
  logic [NUM_IN-1:0]  in_ovr_set;
  logic [NUM_IN-1:0]  w1c_in;
  logic [NUM_OUT-1:0] wr_out;
  logic [NUM_OUT-1:0] out_ovr_set;
  logic [NUM_OUT-1:0] w1c_out;
  logic [WIDTH-1:0]   rd_mux;

  // Inputs are accepted unconditionally once out of reset; overrun is flagged, not back-pressured.
  assign in_ready = {NUM_IN{reset_n}};
  assign cap      = bus.in_valid & in_ready;

  // Input capture, fresh tracking and read-to-clear side effect.
  always_comb begin
    rd_clr = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      rd_clr[i] = !bus.stall && (bus.IO_read_sel == SEL_W'(i));
    end
    for (int i = 0; i < NUM_IN; i++) begin
      in_reg_d[i] = cap[i] ? bus.in_data[i*WIDTH +: WIDTH] : in_reg_q[i];
    end
    // A capture colliding with a read of the same channel is not an overrun: the old word was taken.
    fresh_d    = (fresh_q & ~rd_clr) | cap;
    in_ovr_set = cap & fresh_q & ~rd_clr;
  end

  // Registered read port; stall freezes the result.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (bus.IO_read_sel == SEL_W'(i)) begin
        rd_mux = in_reg_q[i];
      end
    end
    if (bus.IO_read_sel == SelFresh) begin
      rd_mux = WIDTH'(fresh_q);
    end
    if (bus.IO_read_sel == SelOvr) begin
      rd_mux = WIDTH'({out_ovr_q, in_ovr_q});
    end
    if (bus.IO_read_sel == SelMaskR) begin
      rd_mux = WIDTH'(irq_mask_q);
    end
    rd_data_d = bus.stall ? rd_data_q : rd_mux;
  end

  // Core writes: output channels, irq mask, and write-one-to-clear overrun status.
  always_comb begin
    wr_out = '0;
    for (int j = 0; j < NUM_OUT; j++) begin
      wr_out[j] = bus.IO_write_en && (bus.IO_write_sel == SEL_W'(j));
    end
    for (int j = 0; j < NUM_OUT; j++) begin
      out_reg_d[j] = wr_out[j] ? bus.IO_write_data : out_reg_q[j];
    end
    out_valid_d = (out_valid_q & ~bus.out_ready) | wr_out;
    out_ovr_set = wr_out & out_valid_q & ~bus.out_ready;

    irq_mask_d = irq_mask_q;
    if (bus.IO_write_en && (bus.IO_write_sel == SelMaskW)) begin
      irq_mask_d = bus.IO_write_data[NUM_IN-1:0];
    end

    w1c_in  = '0;
    w1c_out = '0;
    if (bus.IO_write_en && (bus.IO_write_sel == SelW1c)) begin
      w1c_in  = bus.IO_write_data[NUM_IN-1:0];
      w1c_out = bus.IO_write_data[NUM_IN+NUM_OUT-1:NUM_IN];
    end
    // Set after clear so a new overrun wins over a simultaneous W1C.
    in_ovr_d  = (in_ovr_q & ~w1c_in) | in_ovr_set;
    out_ovr_d = (out_ovr_q & ~w1c_out) | out_ovr_set;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      in_reg_q    <= '0;
      fresh_q     <= '0;
      in_ovr_q    <= '0;
      irq_mask_q  <= '0;
      out_reg_q   <= '0;
      out_valid_q <= '0;
      out_ovr_q   <= '0;
      rd_data_q   <= '0;
    end else begin
      in_reg_q    <= in_reg_d;
      fresh_q     <= fresh_d;
      in_ovr_q    <= in_ovr_d;
      irq_mask_q  <= irq_mask_d;
      out_reg_q   <= out_reg_d;
      out_valid_q <= out_valid_d;
      out_ovr_q   <= out_ovr_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_data     = out_reg_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.IO_read_data = rd_data_q;
  assign bus.irq          = |(fresh_q & irq_mask_q);

endmodule

// File: tb/tb_agc_io_channel_bank.sv
// Bench for agc_io_channel_bank: directed scenarios with literal expectations, then randomized
// traffic checked every cycle against a per-channel behavioural model.
module tb_agc_io_channel_bank;
  localparam int unsigned NUM_IN  = 5;
  localparam int unsigned NUM_OUT = 4;
  localparam int unsigned WIDTH   = 15;
  localparam int unsigned SEL_W   = 5;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  agc_io_channel_bank_if #(
    .NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT), .WIDTH(WIDTH), .SEL_W(SEL_W)
  ) bus ();

  agc_io_channel_bank #(
    .NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT), .WIDTH(WIDTH), .SEL_W(SEL_W)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clock = ~clock;

  // Model state: one entry per channel, plain status flags.
  logic [WIDTH-1:0] m_in[NUM_IN], n_in[NUM_IN];
  bit               m_fresh[NUM_IN], n_fresh[NUM_IN];
  bit               m_iovr[NUM_IN], n_iovr[NUM_IN];
  bit               m_mask[NUM_IN], n_mask[NUM_IN];
  logic [WIDTH-1:0] m_out[NUM_OUT], n_out[NUM_OUT];
  bit               m_oval[NUM_OUT], n_oval[NUM_OUT];
  bit               m_oovr[NUM_OUT], n_oovr[NUM_OUT];
  logic [WIDTH-1:0] m_rd, n_rd;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NUM_IN; i++) begin
      m_in[i] = '0; m_fresh[i] = 0; m_iovr[i] = 0; m_mask[i] = 0;
    end
    for (int j = 0; j < NUM_OUT; j++) begin
      m_out[j] = '0; m_oval[j] = 0; m_oovr[j] = 0;
    end
    m_rd = '0;
  endtask

  function automatic logic [WIDTH-1:0] read_value(input int rs);
    logic [WIDTH-1:0] v;
    v = '0;
    if (rs < NUM_IN) begin
      v = m_in[rs];
    end else if (rs == NUM_IN) begin
      for (int i = 0; i < NUM_IN; i++) v[i] = m_fresh[i];
    end else if (rs == NUM_IN + 1) begin
      for (int i = 0; i < NUM_IN; i++) v[i] = m_iovr[i];
      for (int j = 0; j < NUM_OUT; j++) v[NUM_IN+j] = m_oovr[j];
    end else if (rs == NUM_IN + 2) begin
      for (int i = 0; i < NUM_IN; i++) v[i] = m_mask[i];
    end
    return v;
  endfunction

  function automatic bit exp_irq();
    for (int i = 0; i < NUM_IN; i++) if (m_fresh[i] && m_mask[i]) return 1'b1;
    return 1'b0;
  endfunction

  // Next state from the current inputs, applied at the coming clock edge.
  task automatic model_step();
    int               rs;
    int               ws;
    bit               en;
    bit               rclr;
    logic [WIDTH-1:0] wd;
    rs = int'(bus.IO_read_sel);
    ws = int'(bus.IO_write_sel);
    en = bus.IO_write_en;
    wd = bus.IO_write_data;
    n_in = m_in; n_fresh = m_fresh; n_iovr = m_iovr; n_mask = m_mask;
    n_out = m_out; n_oval = m_oval; n_oovr = m_oovr; n_rd = m_rd;
    if (!bus.stall) n_rd = read_value(rs);
    if (en && ws == NUM_OUT + 1) begin
      for (int i = 0; i < NUM_IN; i++) if (wd[i]) n_iovr[i] = 0;
      for (int j = 0; j < NUM_OUT; j++) if (wd[NUM_IN+j]) n_oovr[j] = 0;
    end
    if (en && ws == NUM_OUT) begin
      for (int i = 0; i < NUM_IN; i++) n_mask[i] = wd[i];
    end
    for (int i = 0; i < NUM_IN; i++) begin
      rclr = !bus.stall && rs == i;
      if (bus.in_valid[i]) begin
        n_in[i] = bus.in_data[i*WIDTH +: WIDTH];
        n_fresh[i] = 1;
        if (m_fresh[i] && !rclr) n_iovr[i] = 1;
      end else if (rclr) begin
        n_fresh[i] = 0;
      end
    end
    for (int j = 0; j < NUM_OUT; j++) begin
      if (m_oval[j] && bus.out_ready[j]) n_oval[j] = 0;
      if (en && ws == j) begin
        n_out[j] = wd;
        n_oval[j] = 1;
        if (m_oval[j] && !bus.out_ready[j]) n_oovr[j] = 1;
      end
    end
  endtask

  task automatic compare_all();
    chk("in_ready", bus.in_ready, {NUM_IN{1'b1}});
    chk("rd_data", bus.IO_read_data, m_rd);
    chk("irq", bus.irq, exp_irq());
    for (int j = 0; j < NUM_OUT; j++) begin
      chk($sformatf("out_data%0d", j), bus.out_data[j*WIDTH +: WIDTH], m_out[j]);
      chk($sformatf("out_valid%0d", j), bus.out_valid[j], m_oval[j]);
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clock);
    m_in = n_in; m_fresh = n_fresh; m_iovr = n_iovr; m_mask = n_mask;
    m_out = n_out; m_oval = n_oval; m_oovr = n_oovr; m_rd = n_rd;
    #1;
    compare_all();
  endtask

  task automatic idle();
    bus.in_valid      = '0;
    bus.out_ready     = '0;
    bus.IO_write_en   = 1'b0;
    bus.IO_write_sel  = '0;
    bus.IO_write_data = '0;
    bus.stall         = 1'b0;
    bus.IO_read_sel   = '1;
  endtask

  task automatic drive_cap(input int ch, input logic [WIDTH-1:0] word);
    bus.in_valid[ch] = 1'b1;
    bus.in_data[ch*WIDTH +: WIDTH] = word;
  endtask

  task automatic drive_wr(input int sel, input logic [WIDTH-1:0] data);
    bus.IO_write_en   = 1'b1;
    bus.IO_write_sel  = SEL_W'(sel);
    bus.IO_write_data = data;
  endtask

  // Asynchronous reset asserted between edges; outputs must drop without waiting for a clock.
  task automatic do_reset();
    @(negedge clock);
    #1 reset_n = 1'b0;
    #1;
    chk("rst_in_ready", bus.in_ready, '0);
    chk("rst_out_valid", bus.out_valid, '0);
    chk("rst_out_data", bus.out_data, '0);
    chk("rst_rd_data", bus.IO_read_data, '0);
    chk("rst_irq", bus.irq, 1'b0);
    model_clear();
    @(posedge clock);
    #1 chk("rst_hold_rd_data", bus.IO_read_data, '0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk("rel_in_ready", bus.in_ready, {NUM_IN{1'b1}});
    chk("rel_rd_data", bus.IO_read_data, '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_data = '0;
    idle();
    do_reset();

    // Capture on ch1 then read it back; fresh bit clears on read.
    idle(); drive_cap(1, 15'h1234); cycle();
    idle(); bus.IO_read_sel = 5'd1; cycle();
    chk("t2_rd_ch1", bus.IO_read_data, 15'h1234);
    idle(); bus.IO_read_sel = SEL_W'(NUM_IN); cycle();
    chk("t2_fresh", bus.IO_read_data, 15'h0000);

    // Two captures without read -> newest word kept, overrun flagged, W1C clears it.
    idle(); drive_cap(0, 15'h0001); cycle();
    idle(); drive_cap(0, 15'h0002); cycle();
    idle(); bus.IO_read_sel = 5'd0; cycle();
    chk("t3_rd_ch0", bus.IO_read_data, 15'h0002);
    idle(); bus.IO_read_sel = SEL_W'(NUM_IN + 1); cycle();
    chk("t3_ovr_set", bus.IO_read_data, 15'h0001);
    idle(); drive_wr(NUM_OUT + 1, 15'h0001); cycle();
    idle(); bus.IO_read_sel = SEL_W'(NUM_IN + 1); cycle();
    chk("t3_ovr_clr", bus.IO_read_data, 15'h0000);

    // Stall freezes read data and suppresses the read side effect.
    idle(); drive_cap(0, 15'h0111); drive_cap(2, 15'h0222); cycle();
    idle(); bus.IO_read_sel = 5'd2; cycle();
    chk("t4_rd_ch2", bus.IO_read_data, 15'h0222);
    for (int k = 0; k < 3; k++) begin
      idle(); bus.stall = 1'b1; bus.IO_read_sel = 5'd0; cycle();
      chk($sformatf("t4_frozen%0d", k), bus.IO_read_data, 15'h0222);
    end
    idle(); bus.IO_read_sel = SEL_W'(NUM_IN); cycle();
    chk("t4_fresh", bus.IO_read_data, 15'h0001);

    // Output overwrite while pending -> overrun; consumer handshake drops valid.
    idle(); drive_wr(3, 15'h7FFF); cycle();
    chk("t5_data_a", bus.out_data[3*WIDTH +: WIDTH], 15'h7FFF);
    chk("t5_valid_a", bus.out_valid[3], 1'b1);
    idle(); drive_wr(3, 15'h0005); cycle();
    chk("t5_data_b", bus.out_data[3*WIDTH +: WIDTH], 15'h0005);
    idle(); bus.IO_read_sel = SEL_W'(NUM_IN + 1); cycle();
    chk("t5_out_ovr", bus.IO_read_data, 15'h0100);
    idle(); bus.out_ready[3] = 1'b1; cycle();
    chk("t5_valid_drop", bus.out_valid[3], 1'b0);
    chk("t5_data_hold", bus.out_data[3*WIDTH +: WIDTH], 15'h0005);
    idle(); drive_wr(NUM_OUT + 1, 15'h0100); cycle();

    // Masked irq from ch2 fresh; read clears it unless a capture collides.
    idle(); drive_wr(NUM_OUT, 15'h0004); cycle();
    chk("t6_irq_masked_off", bus.irq, 1'b0);
    idle(); drive_cap(2, 15'h0333); cycle();
    chk("t6_irq_set", bus.irq, 1'b1);
    idle(); bus.IO_read_sel = 5'd2; cycle();
    chk("t6_irq_clr", bus.irq, 1'b0);
    chk("t6_rd", bus.IO_read_data, 15'h0333);
    idle(); drive_cap(2, 15'h0444); cycle();
    idle(); bus.IO_read_sel = 5'd2; drive_cap(2, 15'h0555); cycle();
    chk("t6_collide_irq", bus.irq, 1'b1);
    chk("t6_collide_old", bus.IO_read_data, 15'h0444);
    idle(); bus.IO_read_sel = 5'd2; cycle();
    chk("t6_new_word", bus.IO_read_data, 15'h0555);
    chk("t6_irq_final", bus.irq, 1'b0);
    idle(); bus.IO_read_sel = SEL_W'(NUM_IN + 1); cycle();
    chk("t6_no_ovr", bus.IO_read_data, 15'h0000);

    // Reset in the middle of activity with an output word pending.
    idle(); drive_wr(0, 15'h1ABC); drive_cap(4, 15'h0777); cycle();
    idle();
    do_reset();

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        for (int i = 0; i < NUM_IN; i++) begin
          bus.in_valid[i] = ($urandom_range(0, 9) < 3);
          bus.in_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
        end
        for (int j = 0; j < NUM_OUT; j++) bus.out_ready[j] = ($urandom_range(0, 1) == 1);
        bus.IO_read_sel   = ($urandom_range(0, 9) < 8) ? SEL_W'($urandom_range(0, NUM_IN + 3))
                                                       : SEL_W'($urandom);
        bus.stall         = ($urandom_range(0, 3) == 0);
        bus.IO_write_en   = ($urandom_range(0, 9) < 4);
        bus.IO_write_sel  = ($urandom_range(0, 9) < 8) ? SEL_W'($urandom_range(0, NUM_OUT + 2))
                                                       : SEL_W'($urandom);
        bus.IO_write_data = WIDTH'($urandom);
        cycle();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
